uart_rx: RTL and testbench

- UART receiver, the receive end of the existing UART transmitter: 8N1 framing, LSB first, idle-high line.
- Oversamples the asynchronous rx_serial line with the system clock, validates the start bit at mid-bit, and samples each data bit and the stop bit at mid-bit.
- Presents each good byte with a one-cycle valid strobe; flags bad stop bits as a framing error.
- Sits between the chip pad/TT input pin and downstream byte consumers (command decoder, loopback to uart_tx).

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sync.sv | 33 +++
 rtl/uart_rx.sv | 168 ++++++++++++++++
 tb/tb_uart_rx.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and helpers for uart_rx / uart_tx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    CLEANUP    = 3'd4,
    BREAK_WAIT = 3'd5
  } rx_state_t;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync.sv
// ============================================================================
// Module      : uart_sync
// Description : N-flop synchronizer for an asynchronous input, resets to 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  // Reset to 1 so an idle-high line never looks like a start bit after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, mid-bit sampling, framing-error detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_rx
  import uart_pkg::*;
#(
  parameter int FREQUENCY = 10000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic [7:0] rx_byte,
  output logic       rx_dv,
  output logic       rx_frame_err,
  output logic       rx_active
);

  localparam int CLKS_PER_BIT = clks_per_bit(FREQUENCY, BAUD_RATE);
  localparam int HALF_BIT     = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_cnt_half = CNT_W'(HALF_BIT);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(UART_DATA_BITS - 1);

  logic                      w_rx_s;
  rx_state_t                 r_state;
  rx_state_t                 w_state_nxt;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic [IDX_W-1:0]          r_idx;
  logic [IDX_W-1:0]          w_idx_nxt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] w_shift_nxt;
  logic [7:0]                w_byte_nxt;
  logic                      w_dv_nxt;
  logic                      w_err_nxt;
  logic                      w_active_nxt;

  uart_sync #(
    .STAGES(2)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx_serial),
    .q    (w_rx_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      rx_byte      <= 8'h00;
      rx_dv        <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_active    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_shift      <= w_shift_nxt;
      rx_byte      <= w_byte_nxt;
      rx_dv        <= w_dv_nxt;
      rx_frame_err <= w_err_nxt;
      rx_active    <= w_active_nxt;
    end
  end

  // Counter compares precede increments, so r_cnt never exceeds CLKS_PER_BIT-1.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_shift_nxt  = r_shift;
    w_byte_nxt   = rx_byte;
    w_dv_nxt     = 1'b0;
    w_err_nxt    = 1'b0;
    w_active_nxt = rx_active;

    case (r_state)
      IDLE: begin
        w_cnt_nxt    = '0;
        w_idx_nxt    = '0;
        w_active_nxt = 1'b0;
        if (!w_rx_s) begin
          w_state_nxt  = START;
          w_active_nxt = 1'b1;
        end
      end

      START: begin
        if (r_cnt == c_cnt_half) begin
          w_cnt_nxt = '0;
          if (!w_rx_s) begin
            w_state_nxt = DATA;
          end else begin
            w_state_nxt  = IDLE;
            w_active_nxt = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (r_cnt == c_cnt_last) begin
          w_cnt_nxt          = '0;
          w_shift_nxt[r_idx] = w_rx_s;
          if (r_idx == c_idx_last) begin
            w_idx_nxt   = '0;
            w_state_nxt = STOP;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (r_cnt == c_cnt_last) begin
          w_cnt_nxt    = '0;
          w_active_nxt = 1'b0;
          if (w_rx_s) begin
            w_byte_nxt  = r_shift;
            w_dv_nxt    = 1'b1;
            w_state_nxt = CLEANUP;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = BREAK_WAIT;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      CLEANUP: begin
        w_state_nxt = IDLE;
      end

      // A held-low line must return high before another start bit is accepted.
      BREAK_WAIT: begin
        if (w_rx_s) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt  = IDLE;
        w_cnt_nxt    = '0;
        w_idx_nxt    = '0;
        w_active_nxt = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking scoreboard bench for uart_rx (16 clocks per bit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int CLK_NS = 10;
  localparam int BIT_NS = 16 * CLK_NS;

  logic       clk;
  logic       reset;
  logic       rx_serial;
  logic [7:0] rx_byte;
  logic       rx_dv;
  logic       rx_frame_err;
  logic       rx_active;

  int         vectors;
  int         miscompares;
  int         edge_cnt;
  int         dv_count;
  int         err_count;
  int         last_dv_edge;
  bit         prev_dv;
  bit         active_seen;
  logic [7:0] last_good;
  logic [7:0] exp_b;
  logic [7:0] exp_q[$];

  uart_rx #(
    .FREQUENCY(160),
    .BAUD_RATE(10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_serial   (rx_serial),
    .rx_byte     (rx_byte),
    .rx_dv       (rx_dv),
    .rx_frame_err(rx_frame_err),
    .rx_active   (rx_active)
  );

  initial begin
    clk = 1'b0;
    forever #(CLK_NS / 2) clk = ~clk;
  end

  initial begin
    edge_cnt = 0;
    forever begin
      @(posedge clk);
      edge_cnt++;
    end
  end

  // Scoreboard monitor: pops one expected byte per rx_dv strobe.
  initial begin
    dv_count = 0;
    err_count = 0;
    last_dv_edge = -1;
    prev_dv = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (rx_active === 1'b1) active_seen = 1'b1;
        if (rx_dv === 1'b1 && rx_frame_err === 1'b1) begin
          vectors++;
          miscompares++;
          $display("FAIL strobe_exclusive: got dv=1 err=1, expected at most one high");
        end
        if (rx_dv === 1'b1 && prev_dv) begin
          vectors++;
          miscompares++;
          $display("FAIL dv_width: got dv high 2+ cycles, expected 1 cycle");
        end
        if (rx_dv === 1'b1) begin
          dv_count++;
          last_dv_edge = edge_cnt;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_dv: got byte %02h, expected no strobe", rx_byte);
          end else begin
            exp_b = exp_q.pop_front();
            if (rx_byte !== exp_b) begin
              miscompares++;
              $display("FAIL rx_byte: got %02h, expected %02h", rx_byte, exp_b);
            end
          end
        end
        if (rx_frame_err === 1'b1) err_count++;
        prev_dv = (rx_dv === 1'b1);
      end else begin
        prev_dv = 1'b0;
      end
    end
  end

  task automatic send_frame(input logic [7:0] data, input logic stop, input int p);
    rx_serial = 1'b0;
    #(p);
    for (int i = 0; i < 8; i++) begin
      rx_serial = data[i];
      #(p);
    end
    rx_serial = stop;
    #(p);
  endtask

  task automatic wait_edge(input int n);
    while (edge_cnt < n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx_serial = 1'b1;
    #(3 * CLK_NS + 2);
    vectors += 4;
    if (rx_byte !== 8'h00) begin miscompares++; $display("FAIL reset_byte: got %02h, expected 00", rx_byte); end
    if (rx_dv !== 1'b0) begin miscompares++; $display("FAIL reset_dv: got %b, expected 0", rx_dv); end
    if (rx_frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b, expected 0", rx_frame_err); end
    if (rx_active !== 1'b0) begin miscompares++; $display("FAIL reset_active: got %b, expected 0", rx_active); end
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    last_good = 8'h00;
  endtask

  task automatic test_single_frame();
    int t0;
    int dv0;
    dv0 = dv_count;
    exp_q.push_back(8'hA5);
    @(posedge clk);
    #1;
    t0 = edge_cnt + 1;
    fork
      send_frame(8'hA5, 1'b1, BIT_NS);
      begin
        wait_edge(t0 + 1);
        vectors++;
        if (rx_active !== 1'b0) begin miscompares++; $display("FAIL active_t0p1: got %b, expected 0", rx_active); end
        wait_edge(t0 + 2);
        vectors++;
        if (rx_active !== 1'b1) begin miscompares++; $display("FAIL active_t0p2: got %b, expected 1", rx_active); end
        wait_edge(t0 + 153);
        vectors += 2;
        if (rx_active !== 1'b1) begin miscompares++; $display("FAIL active_t0p153: got %b, expected 1", rx_active); end
        if (rx_dv !== 1'b0) begin miscompares++; $display("FAIL dv_early: got %b, expected 0", rx_dv); end
        wait_edge(t0 + 154);
        vectors++;
        if (rx_active !== 1'b0) begin miscompares++; $display("FAIL active_t0p154: got %b, expected 0", rx_active); end
      end
    join
    repeat (10) @(negedge clk);
    vectors += 3;
    if (last_dv_edge !== t0 + 154) begin miscompares++; $display("FAIL dv_edge: got %0d, expected %0d", last_dv_edge, t0 + 154); end
    if (dv_count - dv0 !== 1) begin miscompares++; $display("FAIL single_dv_count: got %0d, expected 1", dv_count - dv0); end
    if (rx_byte !== 8'hA5) begin miscompares++; $display("FAIL single_byte: got %02h, expected a5", rx_byte); end
    last_good = 8'hA5;
  endtask

  task automatic test_glitch();
    int dv0;
    int err0;
    dv0 = dv_count;
    err0 = err_count;
    @(posedge clk);
    #1;
    active_seen = 1'b0;
    rx_serial = 1'b0;
    #(5 * CLK_NS);
    rx_serial = 1'b1;
    repeat (40) @(negedge clk);
    vectors += 4;
    if (active_seen !== 1'b1) begin miscompares++; $display("FAIL glitch_active_pulse: got %b, expected 1", active_seen); end
    if (dv_count - dv0 !== 0) begin miscompares++; $display("FAIL glitch_dv: got %0d, expected 0", dv_count - dv0); end
    if (err_count - err0 !== 0) begin miscompares++; $display("FAIL glitch_err: got %0d, expected 0", err_count - err0); end
    if (rx_active !== 1'b0) begin miscompares++; $display("FAIL glitch_idle: got %b, expected 0", rx_active); end
  endtask

  task automatic test_back_to_back();
    int dv0;
    dv0 = dv_count;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    @(posedge clk);
    #1;
    send_frame(8'h00, 1'b1, BIT_NS);
    send_frame(8'hFF, 1'b1, BIT_NS);
    send_frame(8'h55, 1'b1, BIT_NS);
    repeat (20) @(negedge clk);
    vectors += 2;
    if (dv_count - dv0 !== 3) begin miscompares++; $display("FAIL b2b_dv_count: got %0d, expected 3", dv_count - dv0); end
    if (exp_q.size() !== 0) begin miscompares++; $display("FAIL b2b_pending: got %0d left, expected 0", exp_q.size()); end
    last_good = 8'h55;
  endtask

  task automatic test_framing_error();
    int dv0;
    int err0;
    dv0 = dv_count;
    err0 = err_count;
    @(posedge clk);
    #1;
    send_frame(8'h3C, 1'b0, BIT_NS);
    #(40 * BIT_NS);
    vectors += 4;
    if (err_count - err0 !== 1) begin miscompares++; $display("FAIL ferr_count: got %0d, expected 1", err_count - err0); end
    if (dv_count - dv0 !== 0) begin miscompares++; $display("FAIL ferr_dv: got %0d, expected 0", dv_count - dv0); end
    if (rx_byte !== last_good) begin miscompares++; $display("FAIL ferr_byte_held: got %02h, expected %02h", rx_byte, last_good); end
    if (rx_active !== 1'b0) begin miscompares++; $display("FAIL ferr_active: got %b, expected 0", rx_active); end
    rx_serial = 1'b1;
    #(2 * BIT_NS);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, BIT_NS);
    repeat (20) @(negedge clk);
    vectors += 3;
    if (rx_byte !== 8'h81) begin miscompares++; $display("FAIL ferr_recover_byte: got %02h, expected 81", rx_byte); end
    if (dv_count - dv0 !== 1) begin miscompares++; $display("FAIL ferr_recover_dv: got %0d, expected 1", dv_count - dv0); end
    if (err_count - err0 !== 1) begin miscompares++; $display("FAIL ferr_extra_err: got %0d, expected 1", err_count - err0); end
    last_good = 8'h81;
  endtask

  task automatic test_reset_mid_frame();
    int dv0;
    int err0;
    @(posedge clk);
    #1;
    fork
      send_frame(8'h7E, 1'b1, BIT_NS);
      begin
        #(5 * BIT_NS + BIT_NS / 2);
        reset = 1'b0;
        #1;
        vectors += 4;
        if (rx_byte !== 8'h00) begin miscompares++; $display("FAIL midrst_byte: got %02h, expected 00", rx_byte); end
        if (rx_dv !== 1'b0) begin miscompares++; $display("FAIL midrst_dv: got %b, expected 0", rx_dv); end
        if (rx_frame_err !== 1'b0) begin miscompares++; $display("FAIL midrst_err: got %b, expected 0", rx_frame_err); end
        if (rx_active !== 1'b0) begin miscompares++; $display("FAIL midrst_active: got %b, expected 0", rx_active); end
      end
    join
    #(BIT_NS);
    @(negedge clk);
    reset = 1'b1;
    dv0 = dv_count;
    err0 = err_count;
    #(3 * BIT_NS);
    vectors += 2;
    if (dv_count - dv0 !== 0) begin miscompares++; $display("FAIL midrst_no_dv: got %0d, expected 0", dv_count - dv0); end
    if (err_count - err0 !== 0) begin miscompares++; $display("FAIL midrst_no_err: got %0d, expected 0", err_count - err0); end
    exp_q.push_back(8'h12);
    @(posedge clk);
    #1;
    send_frame(8'h12, 1'b1, BIT_NS);
    repeat (20) @(negedge clk);
    vectors += 2;
    if (rx_byte !== 8'h12) begin miscompares++; $display("FAIL midrst_next_byte: got %02h, expected 12", rx_byte); end
    if (dv_count - dv0 !== 1) begin miscompares++; $display("FAIL midrst_next_dv: got %0d, expected 1", dv_count - dv0); end
    last_good = 8'h12;
  endtask

  // Bit periods of 16.5 and 15.5 clocks, roughly +/-3% off nominal.
  task automatic test_baud_tolerance();
    int periods[2];
    int dv0;
    periods[0] = 165;
    periods[1] = 155;
    for (int k = 0; k < 2; k++) begin
      dv0 = dv_count;
      exp_q.push_back(8'hC3);
      @(posedge clk);
      #1;
      send_frame(8'hC3, 1'b1, periods[k]);
      repeat (30) @(negedge clk);
      vectors += 2;
      if (rx_byte !== 8'hC3) begin miscompares++; $display("FAIL baud_byte_%0dns: got %02h, expected c3", periods[k], rx_byte); end
      if (dv_count - dv0 !== 1) begin miscompares++; $display("FAIL baud_dv_%0dns: got %0d, expected 1", periods[k], dv_count - dv0); end
    end
    last_good = 8'hC3;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    active_seen = 1'b0;
    last_good = 8'h00;
    test_reset();
    test_single_frame();
    test_glitch();
    test_back_to_back();
    test_framing_error();
    test_reset_mid_frame();
    test_baud_tolerance();
    repeat (10) @(negedge clk);
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
